// File: rtl/c17_bist_array.sv
// Array of c17 benchmark channels with a registered functional path and an LFSR/MISR BIST engine.
// Optional stuck-at fault injection on one core output is enabled by defining C17_BIST_FAULT_INJ_EN.
module c17_bist_array #(
  parameter int          CHANNELS = 4,
  parameter int          PATTERNS = 64,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [5*CHANNELS-1:0]   in_data,
  output logic                    out_valid,
  output logic [2*CHANNELS-1:0]   out_data,
  input  logic                    bist_start,
  input  logic [15:0]             bist_golden,
  output logic                    bist_busy,
  output logic                    bist_done,
  output logic                    bist_pass,
  output logic [15:0]             bist_signature
`ifdef C17_BIST_FAULT_INJ_EN
  ,
  input  logic                    fi_en,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] fi_chan,
  input  logic                    fi_sel,
  input  logic                    fi_val
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [15:0] LAST = 16'(PATTERNS - 1);

  state_t                state_q, state_d;
  logic                  vld_q;
  logic [15:0]           lfsr, misr, cnt;
  logic [15:0]           fold;
  logic [2*CHANNELS-1:0] func_out, bist_out;
  logic                  in_fire;

  // Returns {o23, o22} for inputs {i7, i6, i3, i2, i1}.
  function automatic logic [1:0] c17(input logic [4:0] x);
    logic nand36;
    nand36 = ~(x[2] & x[3]);
    c17 = {nand36 & (x[1] | x[4]), (x[0] & x[2]) | (x[1] & nand36)};
  endfunction

  function automatic logic [4:0] lfsr_taps(input logic [15:0] l, input int c);
    logic [4:0] v;
    for (int k = 0; k < 5; k++) v[k] = l[(5 * c + k) % 16];
    return v;
  endfunction

  always_comb begin
    func_out = '0;
    bist_out = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      func_out[2*c +: 2] = c17(in_data[5*c +: 5]);
      bist_out[2*c +: 2] = c17(lfsr_taps(lfsr, c));
`ifdef C17_BIST_FAULT_INJ_EN
      if (fi_en && int'(fi_chan) == c) begin
        func_out[2*c + int'(fi_sel)] = fi_val;
        bist_out[2*c + int'(fi_sel)] = fi_val;
      end
`endif
    end
  end

  // Output bit i lands on MISR bit i mod 16.
  always_comb begin
    fold = '0;
    for (int i = 0; i < 2 * CHANNELS; i++) fold[i % 16] = fold[i % 16] ^ bist_out[i];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bist_start) state_d = RUN;
      RUN:     if (cnt == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_fire   = in_valid && (state_q == IDLE);
  assign out_valid = vld_q && (state_q == IDLE);
  assign bist_busy = (state_q != IDLE);
  assign bist_done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      vld_q          <= 1'b0;
      out_data       <= '0;
      bist_pass      <= 1'b0;
      bist_signature <= '0;
      lfsr           <= SEED;
      misr           <= '0;
      cnt            <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= in_fire;
      if (in_fire) out_data <= func_out;
      case (state_q)
        IDLE: if (bist_start) begin
          lfsr      <= SEED;
          misr      <= '0;
          cnt       <= '0;
          bist_pass <= 1'b0;
        end
        RUN: begin
          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
          misr <= {misr[14:0], misr[15] ^ misr[13] ^ misr[12] ^ misr[10]} ^ fold;
          cnt  <= cnt + 16'd1;
        end
        DONE: begin
          bist_signature <= misr;
          bist_pass      <= (misr == bist_golden);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_c17_bist_array.sv
// Scoreboard bench for c17_bist_array: driver queues expectations, a negedge monitor checks them.
module tb_c17_bist_array;
  localparam int          CH  = 4;
  localparam int          PAT = 64;
  localparam logic [15:0] SD  = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst, in_valid, bist_start;
  logic [19:0]   in_data;
  logic [15:0]   bist_golden;
  logic          out_valid, bist_busy, bist_done, bist_pass;
  logic [7:0]    out_data;
  logic [15:0]   bist_signature;
`ifdef C17_BIST_FAULT_INJ_EN
  logic          fi_en = 1'b0, fi_sel = 1'b0, fi_val = 1'b0;
  logic [1:0]    fi_chan = 2'd0;
`endif

  c17_bist_array #(.CHANNELS(CH), .PATTERNS(PAT), .SEED(SD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .bist_start(bist_start),
    .bist_golden(bist_golden), .bist_busy(bist_busy), .bist_done(bist_done),
    .bist_pass(bist_pass), .bist_signature(bist_signature)
`ifdef C17_BIST_FAULT_INJ_EN
    , .fi_en(fi_en), .fi_chan(fi_chan), .fi_sel(fi_sel), .fi_val(fi_val)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] sig; logic pass; } sig_exp_t;
  sig_exp_t    exp_sig[$];
  logic [7:0]  exp_out[$];
  int          checks = 0, errors = 0;
  logic        sig_pending = 1'b0;
  sig_exp_t    mon_e;
  logic [7:0]  mon_o;

  // Hand-computed functional vectors: {i7,i6,i3,i2,i1} per channel.
  logic [19:0] vin [5] = '{20'h0005F, 20'h0021F, 20'h1C1C5, 20'hFFFFF, 20'h00000};
  logic [7:0]  vexp[5] = '{8'h0D,     8'h09,     8'hE1,     8'h55,     8'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] c17_ref(input logic [4:0] x);
    logic i1, i2, i3, i6, i7, o22, o23;
    {i7, i6, i3, i2, i1} = x;
    o22 = (i1 & i3) | (i2 & ~(i3 & i6));
    o23 = ~(i3 & i6) & (i2 | i7);
    return {o23, o22};
  endfunction

  function automatic logic [15:0] model_sig(input logic fen, input int fch,
                                            input int fsel, input logic fval);
    logic [15:0] l, m, outs;
    logic [4:0]  x;
    logic [1:0]  o;
    l = SD;
    m = 16'h0;
    for (int p = 0; p < PAT; p++) begin
      outs = 16'h0;
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < 5; k++) x[k] = l[(5 * c + k) % 16];
        o = c17_ref(x);
        if (fen && fch == c) o[fsel] = fval;
        outs[2*c +: 2] = o;
      end
      m = {m[14:0], ^(m & 16'hB400)} ^ outs;
      l = {l[14:0], ^(l & 16'hB400)};
    end
    return m;
  endfunction

  always @(negedge clk) begin
    if (sig_pending) begin
      sig_pending = 1'b0;
      if (exp_sig.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: signature %0h with no expectation", bist_signature);
      end else begin
        mon_e = exp_sig.pop_front();
        check("bist_signature", bist_signature, mon_e.sig);
        check("bist_pass", bist_pass, mon_e.pass);
      end
    end
    if (bist_done) sig_pending = 1'b1;
    if (out_valid) begin
      if (exp_out.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: out_data %0h with no expectation", out_data);
      end else begin
        mon_o = exp_out.pop_front();
        check("out_data", out_data, mon_o);
      end
    end
  end

  task automatic run_bist(input string tag, input logic [15:0] golden, input logic [15:0] expsig,
                          input logic fvld, input logic [19:0] fdat, input logic [7:0] fexp);
    int n, d;
    sig_exp_t e;
    e.sig  = expsig;
    e.pass = (golden == expsig);
    exp_sig.push_back(e);
    bist_golden = golden;
    bist_start  = 1'b1;
    in_valid    = fvld;
    in_data     = fdat;
    step();
    bist_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = 20'hABCDE;
    if (fvld) begin
      check({tag, " out_valid_in_run"}, out_valid, 1'b0);
      check({tag, " out_data_captured"}, out_data, fexp);
    end
    n = 0;
    d = 0;
    while (bist_busy && n < 200) begin
      if (bist_done) d++;
      n++;
      step();
    end
    check({tag, " busy_cycles"}, n, 65);
    check({tag, " done_pulses"}, d, 1);
    step();
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] gold;
    int nd;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; bist_start = 1'b0; bist_golden = '0;
    repeat (3) step();
    check("rst out_valid", out_valid, 1'b0);
    check("rst out_data", out_data, 8'h00);
    check("rst busy", bist_busy, 1'b0);
    check("rst done", bist_done, 1'b0);
    check("rst pass", bist_pass, 1'b0);
    check("rst signature", bist_signature, 16'h0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = vin[i];
      exp_out.push_back(vexp[i]);
      step();
    end
    in_valid = 1'b0;
    in_data  = 20'hFFFFF;
    step();
    check("hold out_valid", out_valid, 1'b0);
    check("hold out_data", out_data, 8'h00);
    step();
    check("hold out_data2", out_data, 8'h00);

    gold = model_sig(1'b0, 0, 0, 1'b0);
    run_bist("runA", gold ^ 16'h0001, gold, 1'b1, 20'h0005F, 8'h0D);
    run_bist("runB", gold, gold, 1'b0, 20'h0, 8'h0);

    bist_golden = gold;
    bist_start  = 1'b1;
    step();
    bist_start = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort busy", bist_busy, 1'b0);
    check("abort done", bist_done, 1'b0);
    check("abort pass", bist_pass, 1'b0);
    check("abort signature", bist_signature, 16'h0);
    check("abort out_data", out_data, 8'h00);
    check("abort out_valid", out_valid, 1'b0);
    nd = 0;
    for (int i = 0; i < 70; i++) begin
      if (bist_done) nd++;
      step();
    end
    check("abort no_done", nd, 0);

    run_bist("runD", gold, gold, 1'b0, 20'h0, 8'h0);

`ifdef C17_BIST_FAULT_INJ_EN
    fi_en = 1'b1; fi_chan = 2'd0; fi_sel = 1'b0; fi_val = 1'b1;
    in_valid = 1'b1;
    in_data  = 20'h00000;
    exp_out.push_back(8'h01);
    step();
    in_valid = 1'b0;
    step();
    run_bist("fault", gold, model_sig(1'b1, 0, 0, 1'b1), 1'b0, 20'h0, 8'h0);
    check("fault sig_differs", bist_signature != gold, 1'b1);
    fi_en = 1'b0;
    step();
`endif

    check("exp_out drained", exp_out.size(), 0);
    check("exp_sig drained", exp_sig.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
